// File: rtl/jump_control_unit_pkg.sv
// Shared definitions for the jump control unit: opcodes, FSM states and
// the branch-condition helper used by the decoder.
package jump_control_unit_pkg;

    localparam int OPC_W = 5;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_JMP  = 5'b11000;
    localparam opcode_t OP_JZ   = 5'b11110;
    localparam opcode_t OP_JNZ  = 5'b11111;
    localparam opcode_t OP_JC   = 5'b11100;
    localparam opcode_t OP_JNC  = 5'b11101;
    localparam opcode_t OP_CALL = 5'b11001;
    localparam opcode_t OP_RET  = 5'b10001;
    localparam opcode_t OP_RETI = 5'b10000;

    // RUN decides normally; FLUSH swallows the wrong-path slot after a redirect.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } jcu_state_e;

    // True when a plain jump-class opcode should redirect under the given flags.
    function automatic logic jump_taken(input opcode_t op, input logic z, input logic c);
        logic taken;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = z;
            OP_JNZ:  taken = !z;
            OP_JC:   taken = c;
            OP_JNC:  taken = !c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/jcu_ret_stack.sv
// Return stack for the jump control unit: a small LIFO of
// {return address, flags} entries with occupancy and full/empty status.
// Callers must not push when full or pop when empty; such requests are ignored.
module jcu_ret_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     depth
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] top_idx;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign depth   = count;
    // Wraps to DEPTH-1 when full, which is exactly the top entry.
    assign top_idx = count[PTR_W-1:0] - PTR_W'(1);
    assign dout    = mem[top_idx];

    // Occupancy counter; push has precedence but the caller never asserts both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_ONE;
        end else if (pop && !empty) begin
            count <= count - CNT_ONE;
        end
    end

    // Entry storage written at the current occupancy index.
    // NOTE: the array is deliberately not reset; clearing count empties the
    // stack, and unreset storage maps onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/jump_control_unit.sv
// Jump/interrupt controller between decode and the PC mux. Decodes
// jumps, calls and returns, takes prioritised maskable interrupts, keeps
// {return address, flags} on a return stack and drives one-cycle
// redirect and flag-restore strobes one cycle after each decision.
module jump_control_unit
    import jump_control_unit_pkg::*;
#(
    parameter int          INS_W     = 20,
    parameter int          ADDR_W    = 8,
    parameter int          FLAG_W    = 4,
    parameter int          NUM_IRQ   = 4,
    parameter int          STK_DEPTH = 4,
    parameter int unsigned VEC_BASE  = 'hF0,
    parameter int          VEC_SHFT  = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           ins_valid,
    input  logic [INS_W-1:0]               ins,
    input  logic [ADDR_W-1:0]              current_address,
    input  logic [FLAG_W-1:0]              flag_ex,
    input  logic [NUM_IRQ-1:0]             irq,
    input  logic                           irq_en,
    output logic [ADDR_W-1:0]              jmp_loc,
    output logic                           pc_mux_sel,
    output logic [FLAG_W-1:0]              flag_restore,
    output logic                           flag_restore_en,
    output logic [NUM_IRQ-1:0]             irq_ack,
    output logic [$clog2(STK_DEPTH):0]     stk_depth,
    output logic                           stk_err
);

    localparam int ENTRY_W = ADDR_W + FLAG_W;

    // Instruction fields
    opcode_t             opcode;
    logic [ADDR_W-1:0]   target;
    logic                flag_z;
    logic                flag_c;

    assign opcode = ins[INS_W-1 -: OPC_W];
    assign target = ins[ADDR_W-1:0];
    assign flag_z = flag_ex[1];
    assign flag_c = flag_ex[0];

    generate
        if (INS_W - OPC_W > ADDR_W) begin : g_spare_bits
            logic unused_ins_bits;
            assign unused_ins_bits = ^ins[INS_W-OPC_W-1:ADDR_W];
        end
    endgenerate

    // Return stack interface
    logic                stk_push;
    logic                stk_pop;
    logic [ENTRY_W-1:0]  stk_din;
    logic [ENTRY_W-1:0]  stk_dout;
    logic                stk_full;
    logic                stk_empty;

    jcu_ret_stack #(
        .WIDTH (ENTRY_W),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (stk_din),
        .dout    (stk_dout),
        .full    (stk_full),
        .empty   (stk_empty),
        .depth   (stk_depth)
    );

    // Control state
    jcu_state_e          state;
    logic [NUM_IRQ-1:0]  in_service;

    // Interrupt selection results
    logic [NUM_IRQ-1:0]  irq_win;
    logic [ADDR_W-1:0]   irq_vec;
    logic                irq_found;
    logic                irq_take;
    logic [NUM_IRQ-1:0]  svc_lowest;

    // Pick the lowest-index request that outranks every in-service level,
    // and locate the currently active (highest-priority) in-service bit.
    always_comb begin
        logic blocked;
        logic svc_seen;
        // NOTE: combinational blocks use blocking '=' so the running
        // 'blocked'/'found' values propagate through the loop in order;
        // every output also gets a default first so no latch is inferred.
        irq_win    = '0;
        irq_vec    = '0;
        irq_found  = 1'b0;
        svc_lowest = '0;
        blocked    = 1'b0;
        svc_seen   = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            blocked = blocked | in_service[i];
            if (!irq_found && irq[i] && !blocked) begin
                irq_win[i] = 1'b1;
                irq_vec    = ADDR_W'(VEC_BASE + (i << VEC_SHFT));
                irq_found  = 1'b1;
            end
            if (!svc_seen && in_service[i]) begin
                svc_lowest[i] = 1'b1;
                svc_seen      = 1'b1;
            end
        end
    end

    assign irq_take = irq_found && irq_en && !stk_full && (state == ST_RUN);

    // Decision for this cycle
    logic                redirect;
    logic [ADDR_W-1:0]   redirect_tgt;
    logic                restore_en_nxt;
    logic [FLAG_W-1:0]   restore_nxt;
    logic [NUM_IRQ-1:0]  ack_nxt;
    logic [NUM_IRQ-1:0]  svc_set;
    logic [NUM_IRQ-1:0]  svc_clr;
    logic                err_nxt;

    // Resolve interrupt entry or the decoded instruction; interrupts win and
    // drop the instruction, and the FLUSH slot makes no decision at all.
    always_comb begin
        redirect       = 1'b0;
        redirect_tgt   = '0;
        restore_en_nxt = 1'b0;
        restore_nxt    = '0;
        ack_nxt        = '0;
        svc_set        = '0;
        svc_clr        = '0;
        err_nxt        = 1'b0;
        stk_push       = 1'b0;
        stk_pop        = 1'b0;
        stk_din        = '0;
        if (state == ST_RUN) begin
            if (irq_take) begin
                // Return to the interrupted instruction itself so it re-executes.
                stk_push     = 1'b1;
                stk_din      = {current_address, flag_ex};
                redirect     = 1'b1;
                redirect_tgt = irq_vec;
                ack_nxt      = irq_win;
                svc_set      = irq_win;
            end else if (ins_valid) begin
                case (opcode)
                    OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: begin
                        if (jump_taken(opcode, flag_z, flag_c)) begin
                            redirect     = 1'b1;
                            redirect_tgt = target;
                        end
                    end
                    OP_CALL: begin
                        if (stk_full) begin
                            err_nxt = 1'b1;
                        end else begin
                            stk_push     = 1'b1;
                            stk_din      = {current_address + ADDR_W'(1), flag_ex};
                            redirect     = 1'b1;
                            redirect_tgt = target;
                        end
                    end
                    OP_RET, OP_RETI: begin
                        if (stk_empty) begin
                            err_nxt = 1'b1;
                        end else begin
                            stk_pop      = 1'b1;
                            redirect     = 1'b1;
                            redirect_tgt = stk_dout[ENTRY_W-1 -: ADDR_W];
                            if (opcode == OP_RETI) begin
                                restore_en_nxt = 1'b1;
                                restore_nxt    = stk_dout[FLAG_W-1:0];
                                svc_clr        = svc_lowest;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM, in-service mask, sticky error and registered one-cycle outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_RUN;
            in_service      <= '0;
            stk_err         <= 1'b0;
            pc_mux_sel      <= 1'b0;
            jmp_loc         <= '0;
            flag_restore    <= '0;
            flag_restore_en <= 1'b0;
            irq_ack         <= '0;
        end else begin
            case (state)
                ST_RUN:   state <= redirect ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
            in_service      <= (in_service & ~svc_clr) | svc_set;
            stk_err         <= stk_err | err_nxt;
            pc_mux_sel      <= redirect;
            jmp_loc         <= redirect_tgt;
            flag_restore    <= restore_nxt;
            flag_restore_en <= restore_en_nxt;
            irq_ack         <= ack_nxt;
        end
    end

endmodule
